// File: rtl/pulse_gen_mc.sv
// pulse_gen_mc: multi-channel pulse-train generator feeding per-lane serializers.
// Each clk emits one SER_W-bit word per channel (bit 0 is first out on the line).
// Every channel has its own width/delay in bit-times; period and pulse count are shared.
//
// Ports:
//   clk, rst_n       clock; synchronous active-low reset
//   start_i          level; a registered rising edge starts a burst from IDLE
//   abort_i          level; ends an active burst (ARM/RUN) via DONE
//   pulse_num_i      pulses per burst
//   period_i         period in words (0 behaves as 1)
//   width_i/delay_i  per-channel high time / offset in bit-times (slice c = channel c)
//   chan_en_i        per-channel enable
//   busy_o           high in ARM and RUN
//   trig_o           marks word 0 of each period on data_o
//   done_o           one-cycle pulse at burst end
//   pulse_idx_o      index of the pulse shown on data_o
//   data_o           registered output words (slice c = channel c)
//
// Build option: define PULSE_GEN_CONT_EN so that pulse_num_i == 0 runs continuously
// until abort_i. When it is undefined, pulse_num_i == 0 ends the burst straight from ARM.
module pulse_gen_mc #(
  parameter int CH       = 4,
  parameter int SER_W    = 8,
  parameter int WIDTH_W  = 16,
  parameter int NUM_W    = 11,
  parameter int PERIOD_W = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [NUM_W-1:0]      pulse_num_i,
  input  logic [PERIOD_W-1:0]   period_i,
  input  logic [CH*WIDTH_W-1:0] width_i,
  input  logic [CH*WIDTH_W-1:0] delay_i,
  input  logic [CH-1:0]         chan_en_i,
  output logic                  busy_o,
  output logic                  trig_o,
  output logic                  done_o,
  output logic [NUM_W-1:0]      pulse_idx_o,
  output logic [CH*SER_W-1:0]   data_o
);

`ifdef PULSE_GEN_CONT_EN
  localparam bit CONT_EN = 1'b1;
`else
  localparam bit CONT_EN = 1'b0;
`endif

  // Bit position within a period, and the end of the high window (delay + width).
  localparam int ABS_W = PERIOD_W + $clog2(SER_W);
  localparam int END_W = WIDTH_W + 1;
  localparam int CMP_W = (ABS_W > END_W) ? ABS_W : END_W;

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN, S_DONE} state_e;

  state_e                state_q;
  logic                  start_r1_q, start_r2_q, start_edge_q;
  logic [NUM_W-1:0]      num_q, pulse_cnt_q, pidx_q;
  logic [PERIOD_W-1:0]   period_q, word_cnt_q;
  logic [CH*WIDTH_W-1:0] width_q, delay_q;
  logic [CH-1:0]         chen_q;
  logic [CH*SER_W-1:0]   data_d, data_q;
  logic                  trig_q, done_q, busy_q;
  logic                  last_word, last_pulse;

  // Per-bit window test for the word currently addressed by word_cnt_q. The window
  // end is never compared past the current period, so clipping is implicit.
  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic [CMP_W-1:0] lo, hi;
    assign lo = CMP_W'(delay_q[c*WIDTH_W +: WIDTH_W]);
    assign hi = CMP_W'(END_W'(delay_q[c*WIDTH_W +: WIDTH_W]) +
                       END_W'(width_q[c*WIDTH_W +: WIDTH_W]));
    for (genvar b = 0; b < SER_W; b++) begin : g_bit
      logic [CMP_W-1:0] abs_b;
      assign abs_b = CMP_W'(word_cnt_q) * CMP_W'(SER_W) + CMP_W'(b);
      assign data_d[c*SER_W + b] = chen_q[c] & (abs_b >= lo) & (abs_b < hi);
    end
  end

  assign last_word  = (word_cnt_q == period_q - PERIOD_W'(1));
  // In continuous mode a zero count never reaches its last pulse.
  assign last_pulse = !(CONT_EN && num_q == '0) && (pulse_cnt_q == num_q - NUM_W'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // History regs load as "already high" so a start level held through reset
      // produces no edge once reset releases.
      start_r1_q   <= 1'b1;
      start_r2_q   <= 1'b1;
      start_edge_q <= 1'b0;
      state_q      <= S_IDLE;
      num_q        <= '0;
      period_q     <= PERIOD_W'(1);
      width_q      <= '0;
      delay_q      <= '0;
      chen_q       <= '0;
      word_cnt_q   <= '0;
      pulse_cnt_q  <= '0;
      pidx_q       <= '0;
      data_q       <= '0;
      trig_q       <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      start_r1_q   <= start_i;
      start_r2_q   <= start_r1_q;
      start_edge_q <= start_r1_q & ~start_r2_q;
      data_q       <= '0;
      trig_q       <= 1'b0;
      done_q       <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_edge_q) begin
            state_q <= S_ARM;
            busy_q  <= 1'b1;
          end
        end
        S_ARM: begin
          if (abort_i || (!CONT_EN && pulse_num_i == '0)) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= S_RUN;
          end
          num_q       <= pulse_num_i;
          period_q    <= (period_i == '0) ? PERIOD_W'(1) : period_i;
          width_q     <= width_i;
          delay_q     <= delay_i;
          chen_q      <= chan_en_i;
          word_cnt_q  <= '0;
          pulse_cnt_q <= '0;
          pidx_q      <= '0;
        end
        S_RUN: begin
          if (abort_i) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            data_q <= data_d;
            trig_q <= (word_cnt_q == '0);
            pidx_q <= pulse_cnt_q;
            if (last_word) begin
              word_cnt_q  <= '0;
              pulse_cnt_q <= pulse_cnt_q + NUM_W'(1);
              if (last_pulse) begin
                state_q <= S_DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end
            end else begin
              word_cnt_q <= word_cnt_q + PERIOD_W'(1);
            end
          end
        end
        default: state_q <= S_IDLE;  // S_DONE: one cycle, start edges here are dropped
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign trig_o      = trig_q;
  assign done_o      = done_q;
  assign pulse_idx_o = pidx_q;
  assign data_o      = data_q;

endmodule

// File: tb/tb_pulse_gen_mc.sv
module tb_pulse_gen_mc;
  logic        clk, rst_n, start_i, abort_i;
  logic [10:0] pulse_num_i;
  logic [23:0] period_i;
  logic [63:0] width_i, delay_i;
  logic [3:0]  chan_en_i;
  logic        busy_o, trig_o, done_o;
  logic [10:0] pulse_idx_o;
  logic [31:0] data_o;

  pulse_gen_mc #(.CH(4), .SER_W(8), .WIDTH_W(16), .NUM_W(11), .PERIOD_W(24)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i),
    .pulse_num_i(pulse_num_i), .period_i(period_i), .width_i(width_i),
    .delay_i(delay_i), .chan_en_i(chan_en_i), .busy_o(busy_o), .trig_o(trig_o),
    .done_o(done_o), .pulse_idx_o(pulse_idx_o), .data_o(data_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [10:0]      num;
    logic [23:0]      period;
    logic [63:0]      width;
    logic [63:0]      delay;
    logic [3:0]       en;
    logic [7:0][31:0] ew;   // expected data_o per word of a period
  } vec_t;

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp_v);
    n_tot++;
    if (got === exp_v) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", nm, got, exp_v);
  endtask

  function automatic logic [63:0] pack4(input int a, input int b, input int c, input int d);
    pack4 = {d[15:0], c[15:0], b[15:0], a[15:0]};
  endfunction

  function automatic vec_t mk(input int num, input int per, input logic [63:0] w,
                              input logic [63:0] d, input logic [3:0] en,
                              input logic [31:0] e0, input logic [31:0] e1,
                              input logic [31:0] e2, input logic [31:0] e3);
    vec_t v;
    v.num = num[10:0]; v.period = per[23:0]; v.width = w; v.delay = d; v.en = en;
    v.ew = '0;
    v.ew[0] = e0; v.ew[1] = e1; v.ew[2] = e2; v.ew[3] = e3;
    return v;
  endfunction

  // Reference: paint each enabled channel's high span over the period's bit
  // timeline, clipped at the period end, then pick out word w.
  function automatic logic [31:0] model_word(input vec_t v, input int w);
    logic [31:0] r;
    int lim, s, e;
    r = '0;
    lim = ((v.period == 0) ? 1 : int'(v.period)) * 8;
    for (int c = 0; c < 4; c++) begin
      if (v.en[c]) begin
        s = int'(v.delay[c*16 +: 16]);
        e = s + int'(v.width[c*16 +: 16]);
        if (e > lim) e = lim;
        for (int i = s; i < e; i++)
          if (i / 8 == w) r[c*8 + i%8] = 1'b1;
      end
    end
    return r;
  endfunction

  task automatic apply(input vec_t v);
    pulse_num_i = v.num; period_i = v.period; width_i = v.width;
    delay_i = v.delay; chan_en_i = v.en;
  endtask

  // Start a burst with a clean 0->1 edge and check every word, then the ending.
  task automatic run_burst(input vec_t v, input string tag, input bit disturb);
    int per, dcnt, tcnt;
    per = (v.period == 0) ? 1 : int'(v.period);
    apply(v);
    start_i = 1'b0;
    repeat (3) @(negedge clk);
    start_i = 1'b1;
    repeat (4) @(negedge clk);
    chk({tag, "_pre_data"}, data_o, 32'h0);
    chk({tag, "_pre_busy"}, 32'(busy_o), 32'd1);
    dcnt = 0;
    for (int p = 0; p < int'(v.num); p++) begin
      for (int w = 0; w < per; w++) begin
        @(negedge clk);
        if (done_o) dcnt++;
        chk($sformatf("%s_p%0d_w%0d_data", tag, p, w), data_o, v.ew[w]);
        chk($sformatf("%s_p%0d_w%0d_trig", tag, p, w), 32'(trig_o), 32'(w == 0));
        chk($sformatf("%s_p%0d_w%0d_idx", tag, p, w), 32'(pulse_idx_o), 32'(p));
        if (disturb && p == 0 && w == 0) begin
          start_i = 1'b0; width_i = '1; delay_i = '0; chan_en_i = '1;
          period_i = 24'd1; pulse_num_i = 11'd7;
        end
        if (disturb && p == 0 && w == 1) start_i = 1'b1;
      end
    end
    tcnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (done_o) dcnt++;
      if (trig_o) tcnt++;
    end
    chk({tag, "_done_once"}, 32'(dcnt), 32'd1);
    chk({tag, "_post_trig"}, 32'(tcnt), 32'd0);
    chk({tag, "_post_data"}, data_o, 32'h0);
    chk({tag, "_post_busy"}, 32'(busy_o), 32'd0);
  endtask

  vec_t tbl [8];
  vec_t v;
  int   dcnt, tcnt, bcnt, nzcnt;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    tbl[0] = mk(2, 4, pack4(5,0,0,0),  pack4(0,0,0,0),  4'b0001, 32'h1F, 0, 0, 0);
    tbl[1] = mk(2, 4, pack4(0,16,0,0), pack4(0,3,0,0),  4'b0010, 32'hF800, 32'hFF00, 32'h0700, 0);
    tbl[2] = mk(1, 4, pack4(0,0,40,0), pack4(0,0,20,0), 4'b0100, 0, 0, 32'h00F00000, 32'h00FF0000);
    tbl[3] = mk(2, 4, pack4(5,16,40,0), pack4(0,3,20,0), 4'b1111,
                32'h0000F81F, 32'h0000FF00, 32'h00F00700, 32'h00FF0000);
    tbl[4] = mk(1, 4, pack4(5,16,40,0), pack4(0,3,20,0), 4'b1011,
                32'h0000F81F, 32'h0000FF00, 32'h00000700, 0);
    tbl[5] = mk(1, 4, pack4(1,65535,8,4), pack4(31,30,0,32), 4'b1011, 0, 0, 0, 32'h0000C080);
    tbl[6] = mk(3, 0, pack4(3,0,0,0),  pack4(2,0,0,0),  4'b0001, 32'h1C, 0, 0, 0);
    tbl[7] = mk(2, 2, pack4(0,0,0,10), pack4(0,0,0,6),  4'b1000, 32'hC0000000, 32'hFF000000, 0, 0);

    rst_n = 1'b0; start_i = 1'b1; abort_i = 1'b0;
    pulse_num_i = '0; period_i = '0; width_i = '0; delay_i = '0; chan_en_i = '0;
    repeat (3) @(negedge clk);
    chk("rst_data", data_o, 32'h0);
    chk("rst_ctl", 32'({busy_o, trig_o, done_o, pulse_idx_o}), 32'h0);

    // start held high across reset release must not launch a burst
    rst_n = 1'b1;
    bcnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy_o || data_o != 0) bcnt++;
    end
    chk("no_start_thru_rst", 32'(bcnt), 32'd0);

    for (int i = 0; i < 8; i++) run_burst(tbl[i], $sformatf("t%0d", i), 1'b0);

    // restart edge and config changes mid-burst are ignored; no queued start
    run_burst(tbl[3], "disturb", 1'b1);
    bcnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (busy_o) bcnt++;
    end
    chk("no_queued_start", 32'(bcnt), 32'd0);

    // abort in the middle of a long burst
    v = mk(100, 2, pack4(4,0,0,0), pack4(0,0,0,0), 4'b0001, 32'h0F, 0, 0, 0);
    apply(v);
    start_i = 1'b0;
    repeat (3) @(negedge clk);
    start_i = 1'b1;
    repeat (4) @(negedge clk);
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (pulse_idx_o == 11'd3) break;
    end
    chk("abort_reach_idx3", 32'(pulse_idx_o), 32'd3);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    chk("abort_data0", data_o, 32'h0);
    chk("abort_busy0", 32'(busy_o), 32'd0);
    dcnt = int'(done_o);
    repeat (3) begin
      @(negedge clk);
      if (done_o) dcnt++;
    end
    chk("abort_done_once", 32'(dcnt), 32'd1);

`ifdef PULSE_GEN_CONT_EN
    // continuous mode: keeps running past 1000 periods until abort
    v = mk(0, 1, pack4(8,0,0,0), pack4(0,0,0,0), 4'b0001, 32'hFF, 0, 0, 0);
    apply(v);
    start_i = 1'b0;
    repeat (3) @(negedge clk);
    start_i = 1'b1;
    repeat (5) @(negedge clk);
    chk("cont_first_word", data_o, 32'hFF);
    repeat (1100) @(negedge clk);
    chk("cont_busy", 32'(busy_o), 32'd1);
    chk("cont_data", data_o, 32'hFF);
    chk("cont_idx", 32'(pulse_idx_o), 32'd1100);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    chk("cont_abort_data0", data_o, 32'h0);
    dcnt = int'(done_o);
    repeat (3) begin
      @(negedge clk);
      if (done_o) dcnt++;
    end
    chk("cont_done_once", 32'(dcnt), 32'd1);
`else
    // zero pulse count: burst ends straight from ARM with no output
    v = mk(0, 4, pack4(8,0,0,0), pack4(0,0,0,0), 4'b0001, 0, 0, 0, 0);
    apply(v);
    start_i = 1'b0;
    repeat (3) @(negedge clk);
    start_i = 1'b1;
    dcnt = 0; tcnt = 0; nzcnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (done_o) dcnt++;
      if (trig_o) tcnt++;
      if (data_o != 0) nzcnt++;
    end
    chk("num0_done_once", 32'(dcnt), 32'd1);
    chk("num0_no_trig", 32'(tcnt), 32'd0);
    chk("num0_data0", 32'(nzcnt), 32'd0);
    chk("num0_idle", 32'(busy_o), 32'd0);
`endif

    // randomized bursts against the reference model
    for (int i = 0; i < 12; i++) begin
      v.num    = 11'($urandom_range(1, 3));
      v.period = 24'($urandom_range(0, 6));
      v.width  = pack4($urandom_range(0, 50), $urandom_range(0, 50),
                       $urandom_range(0, 50), $urandom_range(0, 50));
      v.delay  = pack4($urandom_range(0, 50), $urandom_range(0, 50),
                       $urandom_range(0, 50), $urandom_range(0, 50));
      v.en     = 4'($urandom);
      for (int w = 0; w < 8; w++) v.ew[w] = model_word(v, w);
      run_burst(v, $sformatf("r%0d", i), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
